max7219_chain_driver: RTL and testbench

MAX7219_CHAIN_DRIVER -- requirements
Module: max7219_chain_driver

---
 rtl/max7219_pkg.sv | 45 ++++
 rtl/spi_frame_tx.sv | 116 +++++++++++
 rtl/max7219_chain_driver.sv | 151 +++++++++++++++
 tb/tb_max7219_chain_driver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 daisy-chain driver: register map,
// sequencer states and the power-up register table.
package max7219_pkg;

  localparam logic [7:0] REG_NOOP      = 8'h00;
  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DIGIT1    = 8'h02;
  localparam logic [7:0] REG_DIGIT2    = 8'h03;
  localparam logic [7:0] REG_DIGIT3    = 8'h04;
  localparam logic [7:0] REG_DIGIT4    = 8'h05;
  localparam logic [7:0] REG_DIGIT5    = 8'h06;
  localparam logic [7:0] REG_DIGIT6    = 8'h07;
  localparam logic [7:0] REG_DIGIT7    = 8'h08;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam logic [2:0] INIT_LAST = 3'd4;
  localparam logic [2:0] ROW_LAST  = 3'd7;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    ROW  = 3'd2,
    INT  = 3'd3,
    GAP  = 3'd4
  } drv_state_t;

  // Power-up sequence: leave shutdown, raw pixel mode, brightness, scan all 8 rows, test off.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {REG_SHUTDOWN, 8'h01};
      3'd1:    w = {REG_DECODE, 8'h00};
      3'd2:    w = {REG_INTENSITY, 4'h0, inten};
      3'd3:    w = {REG_SCANLIM, 8'h07};
      3'd4:    w = {REG_TEST, 8'h00};
      default: w = {REG_NOOP, 8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Mode-0 serialiser for one chained frame: cs framing, MSB-first shifting and
// the mandatory cs-high gap before done is reported.
module spi_frame_tx #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             done,
  output logic             mosi,
  output logic             sclk,
  output logic             cs
);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_TAIL  = 2'd2,
    TX_GAP   = 2'd3
  } tx_state_t;

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  tx_state_t        state_r;
  logic [CW-1:0]    div_r;
  logic [BW-1:0]    bit_r;
  logic [WIDTH-2:0] shreg_r;
  logic             mosi_r;
  logic             sclk_r;
  logic             cs_r;
  logic             done_r;

  // Frame sequencer: each bit spends CLK_DIV cycles with sclk low, then CLK_DIV high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TX_IDLE;
      div_r   <= '0;
      bit_r   <= '0;
      shreg_r <= '0;
      mosi_r  <= 1'b0;
      sclk_r  <= 1'b0;
      cs_r    <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        TX_IDLE: begin
          if (start) begin
            shreg_r <= data[WIDTH-2:0];
            mosi_r  <= data[WIDTH-1];
            cs_r    <= 1'b0;
            div_r   <= '0;
            bit_r   <= '0;
            state_r <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (div_r == DIV_LAST) begin
            div_r <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else begin
              sclk_r <= 1'b0;
              if (bit_r == BIT_LAST) begin
                mosi_r  <= 1'b0;
                state_r <= TX_TAIL;
              end else begin
                bit_r   <= bit_r + BW'(1);
                mosi_r  <= shreg_r[WIDTH-2];
                shreg_r <= {shreg_r[WIDTH-3:0], 1'b0};
              end
            end
          end else begin
            div_r <= div_r + CW'(1);
          end
        end
        TX_TAIL: begin
          if (div_r == DIV_LAST) begin
            div_r   <= '0;
            cs_r    <= 1'b1;
            state_r <= TX_GAP;
          end else begin
            div_r <= div_r + CW'(1);
          end
        end
        TX_GAP: begin
          if (div_r == GAP_LAST) begin
            div_r   <= '0;
            done_r  <= 1'b1;
            state_r <= TX_IDLE;
          end else begin
            div_r <= div_r + CW'(1);
          end
        end
        default: begin
          state_r <= TX_IDLE;
          cs_r    <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_r;
  assign mosi = mosi_r;
  assign sclk = sclk_r;
  assign cs   = cs_r;

endmodule

// File: rtl/max7219_chain_driver.sv
// Sequencer for a chain of MAX7219 8x8 matrices: power-up programming, full
// 8-row refreshes from a captured image, and brightness updates.
module max7219_chain_driver
  import max7219_pkg::*;
#(
  parameter int N_DEV   = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DEV*64-1:0]  frame_data,
  input  logic                 update,
  input  logic [3:0]           intensity,
  output logic                 ready,
  output logic                 busy,
  output logic                 mosi,
  output logic                 sclk,
  output logic                 cs
);

  localparam int W = N_DEV * 16;

  drv_state_t          state_r;
  drv_state_t          job_r;
  logic [N_DEV*64-1:0] frame_r;
  logic [2:0]          idx_r;
  logic [2:0]          row_r;
  logic [3:0]          int_sent_r;
  logic                pending_r;
  logic                start_r;
  logic                ready_r;
  logic                busy_r;
  logic [W-1:0]        tx_data_r;
  logic                tx_done_s;

  function automatic logic [W-1:0] bcast(input logic [15:0] word);
    return {N_DEV{word}};
  endfunction

  // Device 0 sits in the lowest word so the farthest device is shifted out first.
  function automatic logic [W-1:0] row_word(input logic [N_DEV*64-1:0] img, input logic [2:0] r);
    logic [W-1:0] w;
    w = '0;
    for (int d = 0; d < N_DEV; d++) begin
      w[d*16 +: 16] = {REG_DIGIT0 + {5'd0, r}, img[d*64 + r*8 +: 8]};
    end
    return w;
  endfunction

  // Job sequencer; GAP waits for the serialiser and decides what runs next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= INIT;
      job_r      <= INIT;
      frame_r    <= '0;
      idx_r      <= 3'd0;
      row_r      <= 3'd0;
      int_sent_r <= 4'h0;
      pending_r  <= 1'b0;
      start_r    <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b1;
      tx_data_r  <= '0;
    end else begin
      start_r <= 1'b0;
      busy_r  <= 1'b1;
      if (update && ready_r) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        INIT: begin
          tx_data_r <= bcast(init_word(idx_r, intensity));
          if (idx_r == 3'd2) begin
            int_sent_r <= intensity;
          end
          start_r <= 1'b1;
          job_r   <= INIT;
          state_r <= GAP;
        end
        ROW: begin
          tx_data_r <= row_word(frame_r, row_r);
          start_r   <= 1'b1;
          job_r     <= ROW;
          state_r   <= GAP;
        end
        INT: begin
          tx_data_r <= bcast({REG_INTENSITY, 4'h0, int_sent_r});
          start_r   <= 1'b1;
          job_r     <= INT;
          state_r   <= GAP;
        end
        GAP: begin
          if (tx_done_s) begin
            if (job_r == INIT && idx_r != INIT_LAST) begin
              idx_r   <= idx_r + 3'd1;
              state_r <= INIT;
            end else if (job_r == ROW && row_r != ROW_LAST) begin
              row_r   <= row_r + 3'd1;
              state_r <= ROW;
            end else if (job_r == INIT || pending_r || update) begin
              // Updates seen before ready fold into this first refresh.
              ready_r   <= 1'b1;
              frame_r   <= frame_data;
              row_r     <= 3'd0;
              pending_r <= 1'b0;
              state_r   <= ROW;
            end else begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        IDLE: begin
          if (intensity != int_sent_r) begin
            int_sent_r <= intensity;
            state_r    <= INT;
          end else if (update) begin
            frame_r   <= frame_data;
            row_r     <= 3'd0;
            pending_r <= 1'b0;
            state_r   <= ROW;
          end else begin
            busy_r <= 1'b0;
          end
        end
        default: begin
          state_r <= INIT;
          idx_r   <= 3'd0;
        end
      endcase
    end
  end

  spi_frame_tx #(
    .WIDTH   (W),
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (start_r),
    .data  (tx_data_r),
    .done  (tx_done_s),
    .mosi  (mosi),
    .sclk  (sclk),
    .cs    (cs)
  );

  assign ready = ready_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_max7219_chain_driver.sv
// Self-checking bench: decodes the serial pins back into words and compares
// them with transaction lists derived from the register/row rules.
module tb_max7219_chain_driver;

  localparam int NDEV   = 2;
  localparam int DIV    = 2;
  localparam int W      = NDEV * 16;
  localparam int TX_LOW = W * 2 * DIV + DIV;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                update = 1'b0;
  logic [NDEV*64-1:0]  frame_data = '0;
  logic [3:0]          intensity = 4'h0;
  logic                ready, busy, mosi, sclk, cs;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] tx_q[$];
  logic         rdy_q[$];
  int           len_q[$];
  int           rise_q[$];
  int           low_cnt = 0, rises = 0, gap_cnt = 0, min_gap = 1000000, stab_err = 0;
  bit           have_rise = 1'b0;
  logic [W-1:0] shift_v = '0;
  logic         prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, rdy_at_fall = 1'b0;

  max7219_chain_driver #(.N_DEV(NDEV), .CLK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_data (frame_data),
    .update     (update),
    .intensity  (intensity),
    .ready      (ready),
    .busy       (busy),
    .mosi       (mosi),
    .sclk       (sclk),
    .cs         (cs)
  );

  always #5 clk = ~clk;

  // Pin-level decoder sampled mid-cycle.
  always @(negedge clk) begin
    if (!cs) begin
      if (prev_cs) begin
        if (have_rise && gap_cnt < min_gap) min_gap = gap_cnt;
        low_cnt = 1; rises = 0; shift_v = '0; rdy_at_fall = ready;
      end else begin
        low_cnt++;
      end
      if (sclk && !prev_sclk) begin
        rises++;
        shift_v = {shift_v[W-2:0], mosi};
        if (mosi !== prev_mosi) stab_err++;
      end
    end else begin
      if (!prev_cs) begin
        if (!reset) begin
          tx_q.push_back(shift_v); rdy_q.push_back(rdy_at_fall);
          len_q.push_back(low_cnt); rise_q.push_back(rises);
        end
        gap_cnt = 1; have_rise = 1'b1;
      end else begin
        gap_cnt++;
      end
    end
    prev_cs = cs; prev_sclk = sclk; prev_mosi = mosi;
  end

  function automatic logic [W-1:0] bcast_exp(input logic [7:0] a, input logic [7:0] v);
    logic [W-1:0] w = '0;
    for (int d = 0; d < NDEV; d++) w = (w << 16) | W'({a, v});
    return w;
  endfunction

  function automatic logic [W-1:0] row_exp(input logic [NDEV*64-1:0] f, input int r);
    logic [W-1:0] w = '0;
    for (int d = NDEV - 1; d >= 0; d--) w = (w << 16) | W'({8'(r + 1), f[d*64 + r*8 +: 8]});
    return w;
  endfunction

  function automatic logic [W-1:0] init_exp(input int i, input logic [3:0] inten);
    case (i)
      0: return bcast_exp(8'h0C, 8'h01);
      1: return bcast_exp(8'h09, 8'h00);
      2: return bcast_exp(8'h0A, {4'h0, inten});
      3: return bcast_exp(8'h0B, 8'h07);
      default: return bcast_exp(8'h0F, 8'h00);
    endcase
  endfunction

  function automatic logic [NDEV*64-1:0] rand_frame();
    logic [NDEV*64-1:0] f;
    for (int i = 0; i < NDEV * 2; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic pulse_update();
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    if (busy !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout busy=%b after %0d cycles, required 0", tag, busy, budget);
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_cmp++; if (cs !== 1'b1)    begin n_err++; $display("FAIL rst_cs got %b want 1", cs); end
    n_cmp++; if (sclk !== 1'b0)  begin n_err++; $display("FAIL rst_sclk got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0)  begin n_err++; $display("FAIL rst_mosi got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL rst_busy got %b want 1", busy); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ready); end
  endtask

  task automatic test_init();
    logic [W-1:0] exp[$];
    intensity = 4'($urandom_range(0, 9));
    frame_data = rand_frame();
    tx_q.delete(); rdy_q.delete();
    @(negedge clk); reset = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL init_ready_early got %b want 0", ready); end
    pulse_update();
    for (int i = 0; i < 5; i++) exp.push_back(init_exp(i, intensity));
    for (int r = 0; r < 8; r++) exp.push_back(row_exp(frame_data, r));
    wait_idle("init", 5000);
    n_cmp++; if (tx_q.size() != exp.size()) begin n_err++; $display("FAIL init_count got %0d want %0d", tx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++) begin
      n_cmp++; if (tx_q[i] !== exp[i]) begin n_err++; $display("FAIL init_tx[%0d] got %h want %h", i, tx_q[i], exp[i]); end
      n_cmp++; if (rdy_q[i] !== (i >= 5)) begin n_err++; $display("FAIL init_ready[%0d] got %b want %b", i, rdy_q[i], (i >= 5)); end
    end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL init_ready_final got %b want 1", ready); end
  endtask

  task automatic test_frame_pattern();
    logic [7:0] rows[8] = '{8'hFF, 8'h81, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h81, 8'hFF};
    logic [NDEV*64-1:0] f = '0;
    logic [W-1:0] exp[$];
    for (int r = 0; r < 8; r++) f[r*8 +: 8] = rows[r];
    for (int r = 0; r < 8; r++) exp.push_back(row_exp(f, r));
    tx_q.delete(); rdy_q.delete();
    frame_data = f;
    pulse_update();
    frame_data = rand_frame();
    wait_idle("pattern", 3000);
    n_cmp++; if (tx_q.size() != 8) begin n_err++; $display("FAIL pattern_count got %0d want 8", tx_q.size()); end
    for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
      n_cmp++; if (tx_q[i] !== exp[i]) begin n_err++; $display("FAIL pattern_row[%0d] got %h want %h", i, tx_q[i], exp[i]); end
    end
  endtask

  task automatic test_random_updates();
    logic [W-1:0] exp[$];
    for (int it = 0; it < 3; it++) begin
      exp.delete(); tx_q.delete(); rdy_q.delete();
      frame_data = rand_frame();
      for (int r = 0; r < 8; r++) exp.push_back(row_exp(frame_data, r));
      pulse_update();
      wait_idle("rand", 3000);
      n_cmp++; if (tx_q.size() != 8) begin n_err++; $display("FAIL rand_count[%0d] got %0d want 8", it, tx_q.size()); end
      for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
        n_cmp++; if (tx_q[i] !== exp[i]) begin n_err++; $display("FAIL rand_row[%0d][%0d] got %h want %h", it, i, tx_q[i], exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp[$];
    int k = 0;
    tx_q.delete(); rdy_q.delete();
    frame_data = rand_frame();
    for (int r = 0; r < 8; r++) exp.push_back(row_exp(frame_data, r));
    pulse_update();
    while (tx_q.size() < 2 && k < 2000) begin @(negedge clk); k++; end
    for (int j = 0; j < 3; j++) begin
      frame_data = rand_frame();
      pulse_update();
      repeat (20) @(negedge clk);
    end
    for (int r = 0; r < 8; r++) exp.push_back(row_exp(frame_data, r));
    wait_idle("b2b", 6000);
    n_cmp++; if (tx_q.size() != 16) begin n_err++; $display("FAIL b2b_count got %0d want 16", tx_q.size()); end
    for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
      n_cmp++; if (tx_q[i] !== exp[i]) begin n_err++; $display("FAIL b2b_tx[%0d] got %h want %h", i, tx_q[i], exp[i]); end
    end
  endtask

  task automatic test_intensity();
    logic [W-1:0] exp[$];
    tx_q.delete(); rdy_q.delete();
    @(negedge clk); intensity = 4'hA;
    wait_idle("int_only", 2000);
    n_cmp++; if (tx_q.size() != 1) begin n_err++; $display("FAIL int_only_count got %0d want 1", tx_q.size()); end
    if (tx_q.size() > 0) begin
      n_cmp++; if (tx_q[0] !== bcast_exp(8'h0A, 8'h0A)) begin n_err++; $display("FAIL int_only_tx got %h want %h", tx_q[0], bcast_exp(8'h0A, 8'h0A)); end
    end
    tx_q.delete(); rdy_q.delete();
    frame_data = rand_frame();
    exp.push_back(bcast_exp(8'h0A, 8'h03));
    for (int r = 0; r < 8; r++) exp.push_back(row_exp(frame_data, r));
    @(negedge clk); intensity = 4'h3; update = 1'b1;
    @(negedge clk); update = 1'b0;
    wait_idle("int_upd", 3000);
    n_cmp++; if (tx_q.size() != 9) begin n_err++; $display("FAIL int_upd_count got %0d want 9", tx_q.size()); end
    for (int i = 0; i < 9 && i < tx_q.size(); i++) begin
      n_cmp++; if (tx_q[i] !== exp[i]) begin n_err++; $display("FAIL int_upd_tx[%0d] got %h want %h", i, tx_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp[$];
    int k = 0;
    tx_q.delete(); rdy_q.delete();
    pulse_update();
    while (tx_q.size() < 1 && k < 2000) begin @(negedge clk); k++; end
    while (!(cs === 1'b0 && rises == 17) && k < 4000) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 4000) begin n_err++; $display("FAIL midrst_reach_bit17 got timeout want bit 17 reached"); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (cs !== 1'b1)    begin n_err++; $display("FAIL midrst_cs got %b want 1", cs); end
    n_cmp++; if (sclk !== 1'b0)  begin n_err++; $display("FAIL midrst_sclk got %b want 0", sclk); end
    n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL midrst_busy got %b want 1", busy); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0", ready); end
    repeat (3) @(negedge clk);
    tx_q.delete(); rdy_q.delete();
    for (int i = 0; i < 5; i++) exp.push_back(init_exp(i, intensity));
    for (int r = 0; r < 8; r++) exp.push_back(row_exp(frame_data, r));
    reset = 1'b0;
    wait_idle("midrst", 5000);
    n_cmp++; if (tx_q.size() != 13) begin n_err++; $display("FAIL midrst_count got %0d want 13", tx_q.size()); end
    for (int i = 0; i < 13 && i < tx_q.size(); i++) begin
      n_cmp++; if (tx_q[i] !== exp[i]) begin n_err++; $display("FAIL midrst_tx[%0d] got %h want %h", i, tx_q[i], exp[i]); end
    end
  endtask

  task automatic test_timing();
    n_cmp++; if (len_q.size() < 40) begin n_err++; $display("FAIL timing_tx_seen got %0d want >=40", len_q.size()); end
    for (int i = 0; i < len_q.size(); i++) begin
      n_cmp++; if (len_q[i] != TX_LOW) begin n_err++; $display("FAIL timing_cs_low[%0d] got %0d want %0d", i, len_q[i], TX_LOW); end
      n_cmp++; if (rise_q[i] != W) begin n_err++; $display("FAIL timing_sclk_rises[%0d] got %0d want %0d", i, rise_q[i], W); end
    end
    n_cmp++; if (min_gap < 2 * DIV) begin n_err++; $display("FAIL timing_gap got %0d want >=%0d", min_gap, 2 * DIV); end
    n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL timing_mosi_stable got %0d unstable edges want 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame_pattern();
    test_random_updates();
    test_back_to_back();
    test_intensity();
    test_reset_mid();
    test_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
